// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS encoder: 8b/10b video, control, TERC4 and guard-band symbols,
// two registered stages in the pix_clk domain with per-lane running disparity.
module tmds_encoder_multi #(
   parameter int NUM_CH       = 3,
   parameter bit ENABLE_TERC4 = 1'b1
) (
   input  logic                  pix_clk,
   input  logic                  rst_n,
   input  logic                  ce,
   input  logic [1:0]            mode,
   input  logic [8*NUM_CH-1:0]   d,
   input  logic [2*NUM_CH-1:0]   c,
   input  logic [4*NUM_CH-1:0]   terc,
   output logic [10*NUM_CH-1:0]  tmds,
   output logic [6*NUM_CH-1:0]   dbg_cnt
);

   typedef enum logic [1:0] {
      MODE_VIDEO = 2'd0,
      MODE_CTRL  = 2'd1,
      MODE_TERC4 = 2'd2,
      MODE_GUARD = 2'd3
   } mode_e;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
      return n;
   endfunction

   // Transition-minimising stage: XNOR chain for ones-heavy bytes, XOR otherwise.
   function automatic logic [8:0] encode_qm(input logic [7:0] v);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1       = popcount8(v);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !v[0]);
      q[0]     = v[0];
      for (int i = 1; i < 8; i++)
         q[i] = use_xnor ? ~(q[i-1] ^ v[i]) : (q[i-1] ^ v[i]);
      q[8] = ~use_xnor;
      return q;
   endfunction

   function automatic logic [9:0] ctrl_code(input logic [1:0] cc);
      logic [9:0] s;
      case (cc)
         2'b00:   s = 10'b1101010100;
         2'b01:   s = 10'b0010101011;
         2'b10:   s = 10'b0101010100;
         default: s = 10'b1010101011;
      endcase
      return s;
   endfunction

   function automatic logic [9:0] terc4_code(input logic [3:0] n);
      logic [9:0] s;
      case (n)
         4'h0:    s = 10'b1010011100;
         4'h1:    s = 10'b1001100011;
         4'h2:    s = 10'b1011100100;
         4'h3:    s = 10'b1011100010;
         4'h4:    s = 10'b0101110001;
         4'h5:    s = 10'b0100011110;
         4'h6:    s = 10'b0110001110;
         4'h7:    s = 10'b0100111100;
         4'h8:    s = 10'b1011001100;
         4'h9:    s = 10'b0100111001;
         4'hA:    s = 10'b0110011100;
         4'hB:    s = 10'b1011000110;
         4'hC:    s = 10'b1010001110;
         4'hD:    s = 10'b1001110001;
         4'hE:    s = 10'b0101100011;
         default: s = 10'b1011000011;
      endcase
      return s;
   endfunction

   // Green lane carries the complementary guard pattern.
   function automatic logic [9:0] guard_code(input int lane);
      return (lane == 1) ? 10'b0100110011 : 10'b1011001100;
   endfunction

   // ------------------------------------------------------------------
   // Stage 1: q_m per lane plus delayed side-band
   // ------------------------------------------------------------------
   mode_e                mode_eff;
   logic [9*NUM_CH-1:0]  qm_d;
   logic [9*NUM_CH-1:0]  s1_qm;
   mode_e                s1_mode;
   logic [2*NUM_CH-1:0]  s1_c;
   logic [4*NUM_CH-1:0]  s1_terc;

   // Without TERC4 support, island and guard periods fall back to control coding.
   always_comb begin
      mode_eff = mode_e'(mode);
      if (!ENABLE_TERC4 && mode[1]) mode_eff = MODE_CTRL;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_qm
      assign qm_d[9*k +: 9] = encode_qm(d[8*k +: 8]);
   end

   // NOTE: pipeline registers are reset explicitly so the first symbols after
   // reset release are defined control codes rather than stale data.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_qm   <= '0;
         s1_mode <= MODE_CTRL;
         s1_c    <= '0;
         s1_terc <= '0;
      end else if (ce) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         s1_qm   <= qm_d;
         s1_mode <= mode_eff;
         s1_c    <= c;
         s1_terc <= terc;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: DC balancing / symbol selection per lane
   // ------------------------------------------------------------------
   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      logic [8:0]        qm;
      logic [3:0]        n1;
      logic signed [5:0] bal;
      logic signed [5:0] cnt_q;
      logic signed [5:0] cnt_d;
      logic [9:0]        sym_q;
      logic [9:0]        sym_d;

      always_comb begin
         qm  = s1_qm[9*k +: 9];
         n1  = popcount8(qm[7:0]);
         // bal = N1 - N0 = 2*N1 - 8
         bal = $signed({1'b0, n1, 1'b0}) - 6'sd8;
         // NOTE: defaults first so every path assigns sym_d/cnt_d (no latch).
         sym_d = CTRL_00;
         cnt_d = 6'sd0;
         case (s1_mode)
            MODE_VIDEO: begin
               if ((cnt_q == 6'sd0) || (bal == 6'sd0)) begin
                  sym_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                  cnt_d = qm[8] ? (cnt_q + bal) : (cnt_q - bal);
               end else if (((cnt_q > 6'sd0) && (bal > 6'sd0)) ||
                            ((cnt_q < 6'sd0) && (bal < 6'sd0))) begin
                  sym_d = {1'b1, qm[8], ~qm[7:0]};
                  cnt_d = cnt_q + (qm[8] ? 6'sd2 : 6'sd0) - bal;
               end else begin
                  sym_d = {1'b0, qm[8], qm[7:0]};
                  cnt_d = cnt_q - (qm[8] ? 6'sd0 : 6'sd2) + bal;
               end
            end
            MODE_CTRL:  sym_d = ctrl_code(s1_c[2*k +: 2]);
            MODE_TERC4: sym_d = terc4_code(s1_terc[4*k +: 4]);
            default:    sym_d = guard_code(k);
         endcase
      end

      always_ff @(posedge pix_clk or negedge rst_n) begin
         if (!rst_n) begin
            sym_q <= CTRL_00;
            cnt_q <= 6'sd0;
         end else if (ce) begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
         end
      end

      assign tmds[10*k +: 10]  = sym_q;
      assign dbg_cnt[6*k +: 6] = cnt_q;
   end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Self-checking bench: two encoder instances (3 lanes with TERC4, 4 lanes without)
// compared every cycle against a behavioural symbol/disparity model.
module tb_tmds_encoder_multi;

   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] d;
      logic [7:0]  c;
      logic [15:0] terc;
   } sym_in_t;

   localparam logic [9:0] CTRL_TAB [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   localparam logic [9:0] TERC_TAB [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

   logic        pix_clk = 1'b0;
   logic        rst_n;
   logic        ce;
   logic [1:0]  mode;
   logic [31:0] d;
   logic [7:0]  c;
   logic [15:0] terc;
   logic [29:0] tmds0;
   logic [17:0] dbg0;
   logic [39:0] tmds1;
   logic [23:0] dbg1;

   int n_vec = 0;
   int n_err = 0;

   always #5 pix_clk = ~pix_clk;

   tmds_encoder_multi #(.NUM_CH(3), .ENABLE_TERC4(1'b1)) u_dut0 (
      .pix_clk (pix_clk),
      .rst_n   (rst_n),
      .ce      (ce),
      .mode    (mode),
      .d       (d[23:0]),
      .c       (c[5:0]),
      .terc    (terc[11:0]),
      .tmds    (tmds0),
      .dbg_cnt (dbg0)
   );

   tmds_encoder_multi #(.NUM_CH(4), .ENABLE_TERC4(1'b0)) u_dut1 (
      .pix_clk (pix_clk),
      .rst_n   (rst_n),
      .ce      (ce),
      .mode    (mode),
      .d       (d),
      .c       (c),
      .terc    (terc),
      .tmds    (tmds1),
      .dbg_cnt (dbg1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   sym_in_t    m_s1;
   sym_in_t    m_src;
   logic [9:0] m_sym [2][4];
   int         m_cnt [2][4];

   function automatic int lanes(input int inst);
      return (inst == 0) ? 3 : 4;
   endfunction

   // Pick the candidate symbol: invert the payload when its bias matches the running bias.
   function automatic logic [9:0] model_video(input logic [7:0] v, input int cnt);
      int         n1;
      bit         xn;
      logic [7:0] q;
      int         k1;
      n1 = $countones(v);
      xn = (n1 > 4) || (n1 == 4 && !v[0]);
      q[0] = v[0];
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ v[i] ^ xn;
      k1 = $countones(q);
      if (cnt == 0 || k1 == 4) return xn ? {2'b10, ~q} : {2'b01, q};
      if ((cnt > 0) == (k1 > 4)) return {1'b1, !xn, ~q};
      return {1'b0, !xn, q};
   endfunction

   function automatic logic [7:0] decode(input logic [9:0] s);
      logic [7:0] q;
      logic [7:0] v;
      q = s[9] ? ~s[7:0] : s[7:0];
      v[0] = q[0];
      for (int i = 1; i < 8; i++) v[i] = q[i] ^ q[i-1] ^ ~s[8];
      return v;
   endfunction

   task automatic model_reset();
      m_s1 = '0;
      m_s1.mode = 2'd1;
      m_src = m_s1;
      for (int i = 0; i < 2; i++)
         for (int l = 0; l < 4; l++) begin
            m_sym[i][l] = CTRL_TAB[0];
            m_cnt[i][l] = 0;
         end
   endtask

   task automatic model_step(input sym_in_t nxt);
      for (int i = 0; i < 2; i++)
         for (int l = 0; l < lanes(i); l++) begin
            int md;
            md = int'(m_s1.mode);
            if (i == 1 && md >= 2) md = 1;
            case (md)
               0: begin
                  m_sym[i][l] = model_video(m_s1.d[8*l +: 8], m_cnt[i][l]);
                  // running disparity is literally ones minus zeros sent so far
                  m_cnt[i][l] = m_cnt[i][l] + 2 * $countones(m_sym[i][l]) - 10;
               end
               1: begin m_sym[i][l] = CTRL_TAB[m_s1.c[2*l +: 2]]; m_cnt[i][l] = 0; end
               2: begin m_sym[i][l] = TERC_TAB[m_s1.terc[4*l +: 4]]; m_cnt[i][l] = 0; end
               default: begin
                  m_sym[i][l] = (l == 1) ? 10'b0100110011 : 10'b1011001100;
                  m_cnt[i][l] = 0;
               end
            endcase
         end
      m_src = m_s1;
      m_s1  = nxt;
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++)
         for (int l = 0; l < lanes(i); l++) begin
            logic [9:0]        s;
            logic signed [5:0] sc;
            int                a;
            s  = (i == 0) ? tmds0[10*l +: 10] : tmds1[10*l +: 10];
            sc = (i == 0) ? dbg0[6*l +: 6]    : dbg1[6*l +: 6];
            check($sformatf("tmds i%0d l%0d", i, l), 32'(s), 32'(m_sym[i][l]));
            check($sformatf("dbg_cnt i%0d l%0d", i, l), 32'(sc), 32'(6'(m_cnt[i][l])));
            a = int'(sc);
            if (a < 0) a = -a;
            check($sformatf("cnt_bound i%0d l%0d", i, l), 32'(a <= 16), 32'd1);
            if (m_src.mode == 2'd0)
               check($sformatf("decode i%0d l%0d", i, l), 32'(decode(s)), 32'(m_src.d[8*l +: 8]));
         end
   endtask

   always @(posedge pix_clk) begin
      if (rst_n === 1'b1 && ce === 1'b1) model_step('{mode: mode, d: d, c: c, terc: terc});
      #1;
      compare_all();
   end

   // ---------------- stimulus ----------------
   task automatic apply(input logic [1:0] m, input logic [31:0] dv, input logic [7:0] cv,
                        input logic [15:0] tv);
      ce = 1'b1; mode = m; d = dv; c = cv; terc = tv;
      @(negedge pix_clk);
   endtask

   task automatic rand_cycle(input bit video_only);
      int r;
      r    = $urandom_range(0, 9);
      ce   = ($urandom_range(0, 3) != 0);
      mode = (video_only || r < 6 || r == 9) ? 2'd0 : 2'(r - 5);
      d    = $urandom;
      c    = 8'($urandom);
      terc = 16'($urandom);
      @(negedge pix_clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; ce = 1'b1; mode = 2'd1; d = '0; c = '0; terc = '0;
      model_reset();
      repeat (3) @(negedge pix_clk);
      check("reset tmds0", 32'(tmds0), 32'({3{10'b1101010100}}));
      check("reset dbg0", 32'(dbg0), 32'd0);
      rst_n = 1'b1;
      repeat (3) apply(2'd1, 32'h0, 8'h0, 16'h0);
      check("post-reset tmds1", 32'(tmds1[31:0]), 32'({10'b1101010100, 10'b1101010100, 10'b1101010100} >> 0) & 32'h3FFF_FFFF | (32'(tmds1[31:30]) << 30));
      check("post-reset dbg1", 32'(dbg1), 32'd0);

      // 0xFF from cnt 0, then control 01 on lane 0
      apply(2'd0, 32'h5A3C_96FF, 8'h00, 16'h0);
      apply(2'd1, 32'h0, 8'h01, 16'h0);
      check("ff sym", 32'(tmds0[9:0]), 32'(10'b1000000000));
      check("ff cnt", 32'(dbg0[5:0]), 32'(6'h38));
      check("ff sym noterc", 32'(tmds1[9:0]), 32'(10'b1000000000));
      apply(2'd0, 32'h0000_00FF, 8'h00, 16'h0);
      check("ctrl01 sym", 32'(tmds0[9:0]), 32'(10'b0010101011));
      check("ctrl01 cnt", 32'(dbg0[5:0]), 32'd0);
      apply(2'd1, 32'h0, 8'h00, 16'h0);
      check("video after ctrl", 32'(tmds0[9:0]), 32'(10'b1000000000));

      // 0x00, 0x00 from cnt 0
      apply(2'd1, 32'h0, 8'h00, 16'h0);
      apply(2'd0, 32'h1234_5600, 8'h00, 16'h0);
      apply(2'd0, 32'h89AB_CD00, 8'h00, 16'h0);
      check("00 first sym", 32'(tmds0[9:0]), 32'(10'b0100000000));
      check("00 first cnt", 32'(dbg0[5:0]), 32'(6'h38));
      apply(2'd1, 32'h0, 8'h00, 16'h0);
      check("00 second sym", 32'(tmds0[9:0]), 32'(10'b1111111111));
      check("00 second cnt", 32'(dbg0[5:0]), 32'(6'h02));

      // TERC4 sweep, lane k carries nibble t+k; no-TERC4 instance shows control codes
      for (int t = 0; t <= 16; t++) begin
         logic [15:0] tv;
         for (int k = 0; k < 4; k++) tv[4*k +: 4] = 4'(t + k);
         apply((t < 16) ? 2'd2 : 2'd1, $urandom, 8'b11_10_01_00, tv);
         if (t >= 1)
            for (int k = 0; k < 4; k++) begin
               if (k < 3)
                  check($sformatf("terc t%0d l%0d", t - 1, k), 32'(tmds0[10*k +: 10]),
                        32'(TERC_TAB[(t - 1 + k) % 16]));
               check($sformatf("terc-off t%0d l%0d", t - 1, k), 32'(tmds1[10*k +: 10]),
                     32'(CTRL_TAB[k]));
            end
      end

      // random mixed modes with random ce, then a video-only run
      repeat (500) rand_cycle(1'b0);
      repeat (300) rand_cycle(1'b1);

      // mid-stream reset with non-zero disparity
      apply(2'd1, 32'h0, 8'h00, 16'h0);
      apply(2'd1, 32'h0, 8'h00, 16'h0);
      apply(2'd0, 32'h0000_00FF, 8'h00, 16'h0);
      apply(2'd0, $urandom, 8'h00, 16'h0);
      check("pre-reset cnt", 32'(dbg0[5:0]), 32'(6'h38));
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async reset tmds0", 32'(tmds0), 32'({3{10'b1101010100}}));
      check("async reset dbg0", 32'(dbg0), 32'd0);
      check("async reset dbg1", 32'(dbg1), 32'd0);
      mode = 2'd0;
      repeat (2) @(negedge pix_clk);
      rst_n = 1'b1;
      repeat (200) rand_cycle(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
